// File: rtl/l1d_snoop_ctrl.sv
// l1d_snoop_ctrl
//   L1D snoop responder. Takes one snoop at a time from the coherence
//   network and resolves the line in priority order:
//   EWRQ > MLFB > pending MSHR > L1D arrays.
//   It then downgrades the MESI state of the hit copy and answers with
//   either a single-beat ack or the full line split into BEATS beats.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   sn_req_*                     snoop request (valid/ready, line address, type)
//   sn_peek_*                    LST + tag RAM read (results arrive one cycle later)
//   ewrq_*, mlfb_*, mshr_*       flattened per-entry address/state/valid vectors
//   sn_rd_*                      line read (src 0 DRAM, 1 EWRQ, 2 MLFB); data one cycle later
//   sn_chg_*                     one-cycle MESI update of the hit copy
//   sn_resp_*                    response beats (valid/ready, data, has_data, last)
//   sn_idle_o                    no snoop in flight
//
// Optional feature
//   `define L1D_SNOOP_STAT_EN adds 32-bit saturating counters
//   sn_stat_req_o / sn_stat_data_o / sn_stat_miss_o.
module l1d_snoop_ctrl #(
    parameter int LINE_ADDR_W = 14,
    parameter int SET_IDX_W   = 2,
    parameter int WAY_NUM     = 4,
    parameter int N_EWRQ      = 4,
    parameter int N_MLFB      = 4,
    parameter int N_MSHR      = 4,
    parameter int LINE_W      = 512,
    parameter int BEAT_W      = 64,
    localparam int TAG_W      = LINE_ADDR_W - SET_IDX_W,
    localparam int WAY_W      = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
    localparam int N_Q_MAX    = (N_EWRQ > N_MLFB) ? N_EWRQ : N_MLFB,
    localparam int PTR_W      = (N_Q_MAX > 1) ? $clog2(N_Q_MAX) : 1,
    localparam int BEATS      = LINE_W / BEAT_W,
    localparam int BEAT_CNT_W = $clog2(BEATS)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sn_req_valid_i,
    output logic                          sn_req_ready_o,
    input  logic [LINE_ADDR_W-1:0]        sn_req_addr_i,
    input  logic [3:0]                    sn_req_type_i,
    output logic                          sn_peek_en_o,
    output logic [SET_IDX_W-1:0]          sn_peek_set_o,
    input  logic [2*WAY_NUM-1:0]          sn_peek_lst_i,
    input  logic [TAG_W*WAY_NUM-1:0]      sn_peek_tag_i,
    input  logic [N_EWRQ*LINE_ADDR_W-1:0] ewrq_addr_i,
    input  logic [2*N_EWRQ-1:0]           ewrq_mesi_i,
    input  logic [N_EWRQ-1:0]             ewrq_vld_i,
    input  logic [N_MLFB*LINE_ADDR_W-1:0] mlfb_addr_i,
    input  logic [2*N_MLFB-1:0]           mlfb_mesi_i,
    input  logic [N_MLFB-1:0]             mlfb_vld_i,
    input  logic [N_MSHR*LINE_ADDR_W-1:0] mshr_addr_i,
    input  logic [N_MSHR-1:0]             mshr_vld_i,
    output logic                          sn_rd_en_o,
    output logic [1:0]                    sn_rd_src_o,
    output logic [PTR_W-1:0]              sn_rd_ptr_o,
    output logic [WAY_W-1:0]              sn_rd_way_o,
    input  logic [LINE_W-1:0]             sn_rd_data_i,
    output logic                          sn_chg_en_o,
    output logic [1:0]                    sn_chg_src_o,
    output logic [PTR_W-1:0]              sn_chg_ptr_o,
    output logic [WAY_W-1:0]              sn_chg_way_o,
    output logic [1:0]                    sn_chg_mesi_o,
    output logic                          sn_resp_valid_o,
    input  logic                          sn_resp_ready_i,
    output logic [BEAT_W-1:0]             sn_resp_data_o,
    output logic                          sn_resp_has_data_o,
    output logic                          sn_resp_last_o,
    output logic                          sn_idle_o
`ifdef L1D_SNOOP_STAT_EN
    ,
    output logic [31:0]                   sn_stat_req_o,
    output logic [31:0]                   sn_stat_data_o,
    output logic [31:0]                   sn_stat_miss_o
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_COMPARE = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_DATA    = 3'd4;
    localparam logic [2:0] ST_ACK     = 3'd5;

    localparam logic [1:0] SRC_DRAM = 2'd0;
    localparam logic [1:0] SRC_EWRQ = 2'd1;
    localparam logic [1:0] SRC_MLFB = 2'd2;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_M = 2'd3;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    logic [2:0]             state_q, state_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]             type_q, type_d;
    logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
    logic [LINE_W-1:0]      line_q, line_d;

    logic [TAG_W-1:0] req_tag;
    logic             type_shared;
    logic             type_inv;

    logic             ewrq_hit, mlfb_hit, mshr_hit, arr_hit;
    logic [PTR_W-1:0] ewrq_idx, mlfb_idx;
    logic [WAY_W-1:0] arr_way;

    logic             cmp_chg;
    logic [1:0]       cmp_src;
    logic [PTR_W-1:0] cmp_ptr;
    logic [WAY_W-1:0] cmp_way;
    logic [1:0]       cmp_old_mesi;
    logic             cmp_miss;
    logic             cmp_has_data;

    assign req_tag     = addr_q[LINE_ADDR_W-1:SET_IDX_W];
    assign type_shared = (type_q == 4'd8);
    // Unknown snoop codes behave like SNP_INV: invalidate, never return data.
    assign type_inv    = !((type_q == 4'd8) || (type_q == 4'd9));

    // Hit detection per source; the !hit guard makes the lowest index/way win.
    always_comb begin
        ewrq_hit = 1'b0;
        ewrq_idx = '0;
        for (int i = 0; i < N_EWRQ; i++) begin
            if (!ewrq_hit && ewrq_vld_i[i] &&
                (ewrq_addr_i[i*LINE_ADDR_W +: LINE_ADDR_W] == addr_q)) begin
                ewrq_hit = 1'b1;
                ewrq_idx = PTR_W'(i);
            end
        end
        mlfb_hit = 1'b0;
        mlfb_idx = '0;
        for (int i = 0; i < N_MLFB; i++) begin
            if (!mlfb_hit && mlfb_vld_i[i] &&
                (mlfb_addr_i[i*LINE_ADDR_W +: LINE_ADDR_W] == addr_q)) begin
                mlfb_hit = 1'b1;
                mlfb_idx = PTR_W'(i);
            end
        end
        mshr_hit = 1'b0;
        for (int i = 0; i < N_MSHR; i++) begin
            if (mshr_vld_i[i] && (mshr_addr_i[i*LINE_ADDR_W +: LINE_ADDR_W] == addr_q)) begin
                mshr_hit = 1'b1;
            end
        end
        // An array way in state I never counts as a hit, even on a stale tag match.
        arr_hit = 1'b0;
        arr_way = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (!arr_hit && (sn_peek_lst_i[2*w +: 2] != MESI_I) &&
                (sn_peek_tag_i[w*TAG_W +: TAG_W] == req_tag)) begin
                arr_hit = 1'b1;
                arr_way = WAY_W'(w);
            end
        end
    end

    // Source selection: a pending MSHR blocks the array lookup but owns no data yet.
    always_comb begin
        cmp_chg      = 1'b0;
        cmp_src      = SRC_DRAM;
        cmp_ptr      = '0;
        cmp_way      = '0;
        cmp_old_mesi = MESI_I;
        cmp_miss     = 1'b0;
        if (ewrq_hit) begin
            cmp_chg      = 1'b1;
            cmp_src      = SRC_EWRQ;
            cmp_ptr      = ewrq_idx;
            cmp_old_mesi = ewrq_mesi_i[2*ewrq_idx +: 2];
        end else if (mlfb_hit) begin
            cmp_chg      = 1'b1;
            cmp_src      = SRC_MLFB;
            cmp_ptr      = mlfb_idx;
            cmp_old_mesi = mlfb_mesi_i[2*mlfb_idx +: 2];
        end else if (mshr_hit) begin
            cmp_chg = 1'b0;
        end else if (arr_hit) begin
            cmp_chg      = 1'b1;
            cmp_src      = SRC_DRAM;
            cmp_way      = arr_way;
            cmp_old_mesi = sn_peek_lst_i[2*arr_way +: 2];
        end else begin
            cmp_miss = 1'b1;
        end
        cmp_has_data = (cmp_old_mesi == MESI_M) && !type_inv;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        beat_d  = beat_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE: begin
                if (sn_req_valid_i) begin
                    addr_d  = sn_req_addr_i;
                    type_d  = sn_req_type_i;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_COMPARE;
            ST_COMPARE: state_d = cmp_has_data ? ST_READ : ST_ACK;
            ST_READ: begin
                line_d  = sn_rd_data_i;
                beat_d  = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (sn_resp_ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_CNT_W'(1);
                    end
                end
            end
            ST_ACK: begin
                if (sn_resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

    assign sn_req_ready_o = (state_q == ST_IDLE);
    assign sn_idle_o      = (state_q == ST_IDLE);
    assign sn_peek_en_o   = (state_q == ST_LOOKUP);
    // Held on the latched set so the DRAM read in COMPARE addresses the same set.
    assign sn_peek_set_o  = addr_q[SET_IDX_W-1:0];

    assign sn_chg_en_o   = (state_q == ST_COMPARE) && cmp_chg;
    assign sn_chg_src_o  = cmp_src;
    assign sn_chg_ptr_o  = cmp_ptr;
    assign sn_chg_way_o  = cmp_way;
    assign sn_chg_mesi_o = type_shared ? MESI_S : MESI_I;

    assign sn_rd_en_o  = (state_q == ST_COMPARE) && cmp_has_data;
    assign sn_rd_src_o = cmp_src;
    assign sn_rd_ptr_o = cmp_ptr;
    assign sn_rd_way_o = cmp_way;

    assign sn_resp_valid_o    = (state_q == ST_DATA) || (state_q == ST_ACK);
    assign sn_resp_has_data_o = (state_q == ST_DATA);
    assign sn_resp_last_o     = (state_q == ST_ACK) ||
                                ((state_q == ST_DATA) && (beat_q == LAST_BEAT));
    assign sn_resp_data_o     = (state_q == ST_DATA) ?
                                line_q[int'(beat_q)*BEAT_W +: BEAT_W] : '0;

`ifdef L1D_SNOOP_STAT_EN
    logic [31:0] stat_req_q, stat_req_d;
    logic [31:0] stat_data_q, stat_data_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    always_comb begin
        stat_req_d  = stat_req_q;
        stat_data_d = stat_data_q;
        stat_miss_d = stat_miss_q;
        if ((state_q == ST_IDLE) && sn_req_valid_i && (stat_req_q != '1)) begin
            stat_req_d = stat_req_q + 32'd1;
        end
        if ((state_q == ST_COMPARE) && cmp_has_data && (stat_data_q != '1)) begin
            stat_data_d = stat_data_q + 32'd1;
        end
        if ((state_q == ST_COMPARE) && cmp_miss && (stat_miss_q != '1)) begin
            stat_miss_d = stat_miss_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_req_q  <= '0;
            stat_data_q <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_req_q  <= stat_req_d;
            stat_data_q <= stat_data_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign sn_stat_req_o  = stat_req_q;
    assign sn_stat_data_o = stat_data_q;
    assign sn_stat_miss_o = stat_miss_q;
`endif

endmodule

// File: doc/l1d_snoop_ctrl.md
# l1d_snoop_ctrl

Parametrised L1D snoop responder sitting between the coherence network's snoop channel and the L1D bank arrays (LST, tag RAM, data RAM), eviction write-back queue (EWRQ) and miss line-fill buffer (MLFB). It accepts one snoop at a time with a valid/ready handshake, resolves hits in priority order EWRQ > MLFB > pending MSHR > arrays, updates the MESI state of the hit copy, and returns either a single-beat ack or a multi-beat line with full response backpressure.

## Interface
- LINE_ADDR_W, 14, line address width (tag + set)
- SET_IDX_W, 2, set index width; TAG_W = LINE_ADDR_W - SET_IDX_W
- WAY_NUM, 4, ways per set; WAY_W = clog2(WAY_NUM)
- N_EWRQ, 4, EWRQ entries; N_MLFB, 4, MLFB entries; N_MSHR, 4, MSHR entries
- LINE_W, 512, line bits; BEAT_W, 64, response beat bits; BEATS = LINE_W/BEAT_W (power of two, ≥2)
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- sn_req_valid_i / sn_req_ready_o  in/out  1  snoop request handshake
- sn_req_addr_i  in  LINE_ADDR_W  line address; set = low SET_IDX_W bits
- sn_req_type_i  in  4  8 = SNP_SHARED, 9 = SNP_UNIQUE, 11 = SNP_INV; other codes treated as SNP_INV
- sn_peek_en_o, sn_peek_set_o  out  1, SET_IDX_W  LST + tag RAM read
- sn_peek_lst_i  in  2*WAY_NUM  per-way MESI (0 I, 1 S, 2 E, 3 M)
- sn_peek_tag_i  in  TAG_W*WAY_NUM  per-way tags
- ewrq_addr_i, ewrq_mesi_i, ewrq_vld_i  in  N_EWRQ×{LINE_ADDR_W, 2, 1}
- mlfb_addr_i, mlfb_mesi_i, mlfb_vld_i  in  N_MLFB×{LINE_ADDR_W, 2, 1}
- mshr_addr_i, mshr_vld_i  in  N_MSHR×{LINE_ADDR_W, 1}
- sn_rd_en_o, sn_rd_src_o, sn_rd_ptr_o, sn_rd_way_o  out  1, 2, clog2(max(N_EWRQ,N_MLFB)), WAY_W  data read (src 0 DRAM, 1 EWRQ, 2 MLFB); DRAM read uses sn_peek_set_o
- sn_rd_data_i  in  LINE_W  read data, one cycle after sn_rd_en_o
- sn_chg_en_o, sn_chg_src_o, sn_chg_ptr_o, sn_chg_way_o, sn_chg_mesi_o  out  state update
- sn_resp_valid_o / sn_resp_ready_i  out/in  1  response handshake
- sn_resp_data_o  out  BEAT_W;  sn_resp_has_data_o  out  1;  sn_resp_last_o  out  1
- sn_idle_o  out  1  high when no snoop in flight

## Operation
- FSM: IDLE → LOOKUP → COMPARE → (READ → DATA) | ACK → IDLE.
- IDLE: sn_req_ready_o=1; on handshake latch addr/type.
- LOOKUP: sn_peek_en_o=1, set from latched addr.
- COMPARE: array responses valid; evaluate EWRQ, MLFB, MSHR, tag hits (valid entries, full line address match; lowest index/way wins). Source = first hit in priority order; none → MISS.
- New MESI: SNP_SHARED → S; SNP_UNIQUE/SNP_INV → I. has_data = source state M and type ≠ SNP_INV.
- COMPARE pulses sn_chg_en_o for one cycle for EWRQ/MLFB/array hits (not MSHR, not MISS, not when array way state is already I).
- has_data → pulse sn_rd_en_o, go READ; else → ACK.
- MSHR hit or MISS: ACK, has_data=0, no change, no read.
- READ: capture sn_rd_data_i into line buffer, go DATA.
- DATA: beat k = buffer[k*BEAT_W +: BEAT_W], k from 0; valid held, data stable until ready; last on k=BEATS-1; handshake on last → IDLE.
- ACK: one beat, has_data=0, last=1, data=0; hold until ready → IDLE.

## Timing
- Reset (async): FSM IDLE, beat counter 0, buffer 0; valid/peek/rd/chg enables 0, sn_req_ready_o=1, sn_idle_o=1, stats 0.
- Accept at T: peek T+1, change/read T+2, ack valid T+3, first data beat T+4; with ready held high, last beat T+3+BEATS.
- Ready low stalls indefinitely; no beat dropped or repeated.
- Next request accepted in the cycle after final response handshake (no overlap).
- Reset mid-response: valid drops immediately; no partial continuation.
- Queue/MSHR inputs sampled only in COMPARE; changes later are ignored.

## Configuration
- L1D_SNOOP_STAT_EN defined: adds outputs sn_stat_req_o, sn_stat_data_o, sn_stat_miss_o (32-bit, saturating at all-ones) counting accepted snoops, data responses, and MISS resolutions (incremented in COMPARE).
- Undefined: counters and ports absent; behaviour otherwise identical.

## Test plan
- SNP_SHARED, array way 2 state M, BEATS=8, ready=1 → chg way 2 mesi 1 at T+2; rd src 0 way 2; 8 beats T+4..T+11, last on beat 7, data matches line.
- SNP_INV, EWRQ entry 1 and array both hit, state M → chg src 1 ptr 1 mesi 0; single ACK at T+3, has_data=0.
- SNP_UNIQUE, only MSHR 3 matches → no chg, no rd; ACK at T+3.
- Data response with ready toggled 1,0,0,1... → every beat held stable while ready=0, beat order 0..7, no duplicates.
- rstn low during beat 3 → valid 0 immediately; after release, new request completes normally.
- With L1D_SNOOP_STAT_EN: 3 snoops (hit M, miss, MSHR hit) → req=3, data=1, miss=1.
